spi_req_sequencer: RTL and testbench

//  Command front-end for SPI_top. Buffers host read/write requests in a FIFO and

---
 rtl/spi_req_sequencer.sv | 172 +++++++++++++++++
 tb/tb_spi_req_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_req_sequencer                                            |
// | Description : Command front-end for SPI_top. Queues host read/write        |
// |               requests, issues them one at a time on wr/addr/din, waits    |
// |               for done (or a watchdog expiry) and returns one in-order     |
// |               response per request on a valid/ready channel.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_req_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,          // asynchronous, active-low
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic                       spi_wr,
  output logic [ADDR_W-1:0]          spi_addr,
  output logic [DATA_W-1:0]          spi_din,
  input  logic [DATA_W-1:0]          spi_dout,
  input  logic                       spi_done,
  input  logic                       spi_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              cmd_wr;
  logic [WD_W-1:0]   wdog;
  logic              wd_expire;

  // Request FIFO flags; req_ready is gated by rst so it reads 0 while held in reset.
  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign req_ready = rst & ~full;
  assign push      = req_valid & req_ready;
  assign pop       = (state == ST_IDLE) & ~empty;
  assign {head_wr, head_addr, head_data} = mem[rd_ptr];

  assign wd_expire = (wdog == WD_LAST);

  // Host-facing and SPI-facing status derived from the FSM state.
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign spi_wr    = (state == ST_WAIT) & cmd_wr;

  // FIFO storage: contents need no reset, occupancy tracking decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_wr, req_addr, req_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: done takes priority over expiry in the same WAIT cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!empty)                state_nxt = ST_WAIT;
      ST_WAIT: if (spi_done || wd_expire) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Command register: loaded on pop, held through WAIT and kept afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr   <= 1'b0;
      spi_addr <= '0;
      spi_din  <= '0;
    end else if (pop) begin
      cmd_wr   <= head_wr;
      spi_addr <= head_addr;
      spi_din  <= head_data;
    end
  end

  // Watchdog: counts WAIT cycles, cleared when the response is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state == ST_WAIT) begin
      wdog <= wdog + WD_W'(1);
    end else if ((state == ST_RESP) && rsp_ready) begin
      wdog <= '0;
    end
  end

  // Response payload capture at the end of WAIT; held stable through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (spi_done) begin
        rsp_data    <= cmd_wr ? '0 : spi_dout;
        rsp_err     <= spi_err;
        rsp_timeout <= 1'b0;
      end else if (wd_expire) begin
        rsp_data    <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_req_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_req_sequencer                                         |
// | Description : Scoreboard bench for spi_req_sequencer with a simple SPI     |
// |               slave model; a second short-timeout instance covers expiry.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_req_sequencer;

  localparam int DEPTH    = 8;
  localparam int LW       = $clog2(DEPTH + 1);
  localparam int TO_MAIN  = 40;
  localparam int TO_SHORT = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic          req_valid = 1'b0, req_wr = 1'b0;
  logic [7:0]    req_addr = '0, req_data = '0;
  logic          req_ready, rsp_valid, rsp_err, rsp_timeout, spi_wr, busy;
  logic          rsp_ready = 1'b1;
  logic [7:0]    rsp_data, spi_addr, spi_din;
  logic [7:0]    spi_dout = '0;
  logic          spi_done = 1'b0, spi_err = 1'b0;
  logic [LW-1:0] level;

  // Short-timeout instance; its SPI side never answers
  logic          t_req_valid = 1'b0, t_req_wr = 1'b0;
  logic [7:0]    t_req_addr = '0, t_req_data = '0;
  logic          t_req_ready, t_rsp_valid, t_rsp_err, t_rsp_timeout, t_spi_wr, t_busy;
  logic          t_rsp_ready = 1'b1;
  logic [7:0]    t_rsp_data, t_spi_addr, t_spi_din;
  logic [7:0]    t_spi_dout = 8'hFF;
  logic          t_spi_done = 1'b0, t_spi_err = 1'b0;
  logic [LW-1:0] t_level;

  spi_req_sequencer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_din(spi_din),
    .spi_dout(spi_dout), .spi_done(spi_done), .spi_err(spi_err),
    .level(level), .busy(busy)
  );

  spi_req_sequencer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TO_SHORT)) dut_to (
    .clk(clk), .rst(rst),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_wr(t_req_wr),
    .req_addr(t_req_addr), .req_data(t_req_data),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
    .rsp_err(t_rsp_err), .rsp_timeout(t_rsp_timeout),
    .spi_wr(t_spi_wr), .spi_addr(t_spi_addr), .spi_din(t_spi_din),
    .spi_dout(t_spi_dout), .spi_done(t_spi_done), .spi_err(t_spi_err),
    .level(t_level), .busy(t_busy)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected response at every accepted response of the main instance
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data 0x%0h err %0b timeout %0b, expected no response",
                 rsp_data, rsp_err, rsp_timeout);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  // Monitor for the short-timeout instance
  always @(negedge clk) begin
    exp_t e;
    if (rst && t_rsp_valid && t_rsp_ready) begin
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL t_rsp_unexpected: got data 0x%0h err %0b timeout %0b, expected no response",
                 t_rsp_data, t_rsp_err, t_rsp_timeout);
      end else begin
        e = exp2_q.pop_front();
        check("t_rsp_data", 32'(t_rsp_data), 32'(e.data));
        check("t_rsp_err", 32'(t_rsp_err), 32'(e.err));
        check("t_rsp_timeout", 32'(t_rsp_timeout), 32'(e.to));
      end
    end
  end

  // SPI slave model: answers resp_delay cycles into WAIT; addr 0xEE always errors
  logic [7:0] slave_mem [256];
  int         wait_cnt   = 0;
  int         resp_delay = 3;
  bit         resp_en    = 1'b1;

  always begin
    @(posedge clk);
    #1;
    spi_done = 1'b0;
    spi_err  = 1'b0;
    if (resp_en && rst && busy && !rsp_valid) begin
      wait_cnt++;
      if (wait_cnt >= resp_delay) begin
        spi_done = 1'b1;
        spi_err  = (spi_addr == 8'hEE);
        if (spi_wr) spi_dout = 8'h77;
        else        spi_dout = (spi_addr == 8'hEE) ? 8'hC3 : slave_mem[spi_addr];
        if (spi_wr && spi_addr != 8'hEE) slave_mem[spi_addr] = spi_din;
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Push one request into the main instance, queueing its expected response
  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input bit exp_rsp, input logic [7:0] ed, input logic ee, input logic et);
    int   n = 0;
    exp_t e;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 300) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: req_ready still 0 after %0d cycles, required 1", n);
    end else if (exp_rsp) begin
      e.data = ed;
      e.err  = ee;
      e.to   = et;
      exp_q.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Wait until all expected responses are returned and the main FSM is idle
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || level != '0) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy || level != '0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
  endtask

  int n;
  int viol;

  initial begin
    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_spi_wr", 32'(spi_wr), 0);
    check("rst_spi_addr", 32'(spi_addr), 0);
    check("rst_level", 32'(level), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    #1;
    check("rst_release_req_ready", 32'(req_ready), 1);
    tick();

    // Write with done after 20 cycles; check issue latency and hold
    resp_delay = 20;
    push(1'b1, 8'h05, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0);
    check("t1_not_issued_yet", 32'(busy), 0);
    tick();
    check("t1_issue_spi_wr", 32'(spi_wr), 1);
    n = 0;
    viol = 0;
    while (busy && !rsp_valid && n < 100) begin
      if (spi_wr !== 1'b1 || spi_addr !== 8'h05 || spi_din !== 8'hA5) viol++;
      n++;
      tick();
    end
    check("t1_cmd_hold_violations", 32'(viol), 0);
    check("t1_wait_cycles", 32'(n), 20);
    wait_drain("t1", 100);
    check("t1_idle_spi_wr", 32'(spi_wr), 0);
    check("t1_idle_spi_addr_kept", 32'(spi_addr), 32'h05);

    // Read back
    resp_delay = 3;
    push(1'b0, 8'h05, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0);
    wait_drain("t2", 100);

    // Fill FIFO with FSM stalled in WAIT; responses in order
    resp_en = 1'b0;
    push(1'b1, 8'h10, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0);
    push(1'b1, 8'h11, 8'h22, 1'b1, 8'h00, 1'b0, 1'b0);
    push(1'b0, 8'h10, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0);
    push(1'b0, 8'h11, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0);
    push(1'b1, 8'hEE, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);
    push(1'b0, 8'hEE, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0);
    push(1'b1, 8'h12, 8'h44, 1'b1, 8'h00, 1'b0, 1'b0);
    push(1'b0, 8'h12, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0);
    push(1'b0, 8'h05, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("t3_full_req_ready", 32'(req_ready), 0);
    check("t3_full_level", 32'(level), 8);
    check("t3_full_busy", 32'(busy), 1);
    resp_en = 1'b1;
    wait_drain("t3", 400);

    // done arriving in the expiry cycle wins; one cycle later times out
    resp_delay = TO_MAIN;
    push(1'b0, 8'h12, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0);
    wait_drain("done_at_expiry", 200);
    resp_delay = TO_MAIN + 1;
    push(1'b0, 8'h12, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_drain("expiry_before_done", 200);
    resp_delay = 3;

    // Response back-pressure with 3 queued
    rsp_ready = 1'b0;
    push(1'b0, 8'h10, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0);
    push(1'b1, 8'h13, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0);
    push(1'b0, 8'h13, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0);
    push(1'b0, 8'h11, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("t5_rsp_valid", 32'(rsp_valid), 1);
    check("t5_level", 32'(level), 3);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h11 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 ||
          spi_wr !== 1'b0 || spi_addr !== 8'h10 || level !== LW'(3)) viol++;
    end
    check("t5_hold_violations", 32'(viol), 0);
    rsp_ready = 1'b1;
    wait_drain("t5", 200);

    // Reset while in WAIT with 2 queued: everything discarded
    resp_en = 1'b0;
    push(1'b1, 8'h20, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    push(1'b1, 8'h21, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    push(1'b1, 8'h22, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    check("t6_pre_level", 32'(level), 2);
    check("t6_pre_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("t6_rst_req_ready", 32'(req_ready), 0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 0);
    check("t6_rst_rsp_data", 32'(rsp_data), 0);
    check("t6_rst_rsp_err", 32'(rsp_err), 0);
    check("t6_rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("t6_rst_spi_wr", 32'(spi_wr), 0);
    check("t6_rst_spi_addr", 32'(spi_addr), 0);
    check("t6_rst_spi_din", 32'(spi_din), 0);
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    resp_en = 1'b1;
    repeat (30) tick();
    check("t6_post_level", 32'(level), 0);
    check("t6_post_busy", 32'(busy), 0);
    check("t6_post_rsp_valid", 32'(rsp_valid), 0);

    // Watchdog on the short-timeout instance: response exactly TIMEOUT cycles after issue
    begin
      exp_t e;
      e.data = 8'h00;
      e.err  = 1'b1;
      e.to   = 1'b1;
      t_req_valid = 1'b1;
      t_req_wr    = 1'b0;
      t_req_addr  = 8'h33;
      check("t4_req_ready", 32'(t_req_ready), 1);
      exp2_q.push_back(e);
      tick();
      t_req_valid = 1'b0;
      tick();
      check("t4_issued_busy", 32'(t_busy), 1);
      check("t4_issued_addr", 32'(t_spi_addr), 32'h33);
      n = 0;
      while (!t_rsp_valid && n < 100) begin
        tick();
        n++;
      end
      check("t4_cycles_to_rsp", 32'(n), TO_SHORT);
      n = 0;
      while ((exp2_q.size() != 0 || t_busy) && n < 20) begin
        tick();
        n++;
      end
      check("t4_drained", 32'(exp2_q.size()), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
